// File: rtl/nocrtl_traffic_pkg.sv
// Shared types and constants for the traffic-injection sources.
package nocrtl_traffic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Galois taps for x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
  localparam logic [31:0] DEFAULT_SEED = 32'hACE1_2345;

  // One right-shifting Galois step
  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return {1'b0, v[31:1]} ^ (v[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/injection_scheduler_if.sv
// Flit output port from an injection source toward the router local input.
interface injection_scheduler_if #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 4
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [DEST_W-1:0] out_dest;

  modport master (output out_valid, output out_data, output out_dest, input out_ready);
  modport slave  (input out_valid, input out_data, input out_dest, output out_ready);
endinterface

// File: rtl/injection_scheduler_lfsr32.sv
// Free-running 32-bit Galois LFSR with a step enable; a zero seed would lock up,
// so it is replaced by 1.
module lfsr32
  import nocrtl_traffic_pkg::*;
#(
  parameter logic [31:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_en,
  output logic [31:0] o_lfsr
);

  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;

  logic [31:0] r_lfsr;

  // Load the seed on reset, otherwise step when enabled
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr <= SEED_EFF;
    end else if (i_en) begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  assign o_lfsr = r_lfsr;

endmodule

// File: rtl/injection_scheduler.sv
// Per-node NoC traffic injector: rate-controlled random hits, a backlog of
// hits that could not be loaded yet, and one output flit register.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | after reset, waiting for the first send phase
// ST_RUN   | hits are generated and loaded into the output register
// ST_DRAIN | no new hits; backlog and pending flit are flushed
// ST_DONE  | drained, nothing outstanding; done is high
module injection_scheduler #(
  parameter int          DATA_W    = 32,
  parameter int          DEST_W    = 4,
  parameter int          NODE_ID   = 0,
  parameter int          RATE_W    = 8,
  parameter int          BACKLOG_W = 6,
  parameter logic [31:0] SEED      = 32'hACE1_2345
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              send,
  input  logic [RATE_W-1:0] rate,
  injection_scheduler_if.master out_if,
  output logic [15:0]       injected_cnt,
  output logic [15:0]       sent_cnt,
  output logic              overflow,
  output logic              done
);
  import nocrtl_traffic_pkg::*;

  localparam int              SEQ_W     = DATA_W - 8;
  localparam logic [7:0]      NODE_TAG  = 8'(NODE_ID);
  localparam logic [DEST_W-1:0] NODE_DEST = DEST_W'(NODE_ID);

  logic [31:0]          w_lfsr;
  logic                 w_unused_lfsr;
  logic                 w_hit;
  logic                 w_handshake;
  logic                 w_slot_free;
  logic                 w_backlog_nz;
  logic                 w_backlog_full;
  logic                 w_load;
  logic                 w_drained;
  logic [DEST_W-1:0]    w_dest_raw;
  logic [DEST_W-1:0]    w_dest;

  state_t               r_state;
  logic                 r_done;
  logic                 r_out_valid;
  logic [DATA_W-1:0]    r_out_data;
  logic [DEST_W-1:0]    r_out_dest;
  logic [SEQ_W-1:0]     r_seq;
  logic [BACKLOG_W-1:0] r_backlog;
  logic                 r_overflow;
  logic [15:0]          r_injected_cnt;
  logic [15:0]          r_sent_cnt;

  lfsr32 #(.SEED(SEED)) u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .i_en   (1'b1),
    .o_lfsr (w_lfsr)
  );

  // Only the low rate bits and the top destination bits are consumed
  assign w_unused_lfsr  = ^w_lfsr;

  assign w_hit          = (r_state == ST_RUN) && (w_lfsr[RATE_W-1:0] < rate);
  assign w_handshake    = r_out_valid && out_if.out_ready;
  assign w_slot_free    = !r_out_valid || out_if.out_ready;
  assign w_backlog_nz   = |r_backlog;
  assign w_backlog_full = &r_backlog;
  assign w_load         = w_slot_free && (w_hit || w_backlog_nz);

  // A node never targets itself; flip the lsb instead
  assign w_dest_raw     = w_lfsr[31 -: DEST_W];
  assign w_dest         = (w_dest_raw == NODE_DEST) ? (NODE_DEST ^ DEST_W'(1)) : w_dest_raw;

  // Drain is complete once no backlog remains and the output register will be
  // empty after this cycle, so done follows the last handshake directly
  assign w_drained      = !w_backlog_nz && w_slot_free;

  // Phase sequencing with a registered done flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (send) r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (!send) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (send) begin
            r_state <= ST_RUN;
          end else if (w_drained) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          if (send) begin
            r_state <= ST_RUN;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Output flit register: load a new flit when free, hold while stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_dest  <= '0;
      r_seq       <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= {NODE_TAG, r_seq};
      r_out_dest  <= w_dest;
      r_seq       <= r_seq + SEQ_W'(1);
    end else if (w_handshake) begin
      r_out_valid <= 1'b0;
    end
  end

  // Backlog of hits not yet loaded; a hit arriving at saturation is lost
  always_ff @(posedge clk) begin
    if (reset) begin
      r_backlog  <= '0;
      r_overflow <= 1'b0;
    end else if (w_hit && !w_load) begin
      if (w_backlog_full) begin
        r_overflow <= 1'b1;
      end else begin
        r_backlog <= r_backlog + BACKLOG_W'(1);
      end
    end else if (w_load && !w_hit) begin
      r_backlog <= r_backlog - BACKLOG_W'(1);
    end
  end

  // Hit and handshake counters, wrapping, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_injected_cnt <= '0;
      r_sent_cnt     <= '0;
    end else begin
      if (w_hit)       r_injected_cnt <= r_injected_cnt + 16'd1;
      if (w_handshake) r_sent_cnt     <= r_sent_cnt + 16'd1;
    end
  end

  assign out_if.out_valid = r_out_valid;
  assign out_if.out_data  = r_out_data;
  assign out_if.out_dest  = r_out_dest;
  assign injected_cnt     = r_injected_cnt;
  assign sent_cnt         = r_sent_cnt;
  assign overflow         = r_overflow;
  assign done             = r_done;

endmodule
